// File: rtl/muldiv_seq.sv
// Iterative MULT/MULTU/DIV/DIVU sequencer owning the HI/LO registers.
// A single 32-step shift/add-subtract datapath, fixed 33-edge latency per operation.
module muldiv_seq #(
    parameter int unsigned XLEN = 32,
    parameter int unsigned ITER = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] A,
    input  logic [XLEN-1:0] B,
    input  logic            flush,
    input  logic            mthi,
    input  logic            mtlo,
    output logic [XLEN-1:0] hi,
    output logic [XLEN-1:0] lo,
    output logic            busy,
    output logic            done
);

    localparam int unsigned CntW = $clog2(ITER);

    typedef enum logic [1:0] {StIdle, StRun, StFin} state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [1:0]        op_q, op_d;
    logic              sa_q, sa_d;
    logic              sb_q, sb_d;
    logic              bz_q, bz_d;
    logic [XLEN-1:0]   a_raw_q, a_raw_d;
    // acc: product upper half / partial remainder; low: multiplier / quotient; opb: addend / divisor
    logic [XLEN-1:0]   acc_q, acc_d;
    logic [XLEN-1:0]   low_q, low_d;
    logic [XLEN-1:0]   opb_q, opb_d;
    logic [XLEN-1:0]   hi_q, hi_d;
    logic [XLEN-1:0]   lo_q, lo_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic              is_signed;
    logic [XLEN-1:0]   mag_a, mag_b;
    logic [XLEN:0]     mul_sum;
    logic [XLEN:0]     div_shift;
    logic [2*XLEN-1:0] prod, prod_fix;
    logic [XLEN-1:0]   quot_fix, rem_fix;

    always_comb begin
        is_signed = ~op[0];
        mag_a     = (is_signed && A[XLEN-1]) ? (~A + 1'b1) : A;
        mag_b     = (is_signed && B[XLEN-1]) ? (~B + 1'b1) : B;

        mul_sum   = {1'b0, acc_q} + {1'b0, (low_q[0] ? opb_q : {XLEN{1'b0}})};
        div_shift = {acc_q, low_q[XLEN-1]};

        prod      = {acc_q, low_q};
        prod_fix  = (~op_q[0] && (sa_q ^ sb_q)) ? (~prod + 1'b1) : prod;
        quot_fix  = (~op_q[0] && (sa_q ^ sb_q)) ? (~low_q + 1'b1) : low_q;
        rem_fix   = (~op_q[0] && sa_q) ? (~acc_q + 1'b1) : acc_q;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        bz_d    = bz_q;
        a_raw_d = a_raw_q;
        acc_d   = acc_q;
        low_d   = low_q;
        opb_d   = opb_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done_d  = 1'b0;

        case (state_q)
            StIdle: begin
                if (start && !flush) begin
                    op_d    = op;
                    sa_d    = is_signed & A[XLEN-1];
                    sb_d    = is_signed & B[XLEN-1];
                    bz_d    = (B == '0);
                    a_raw_d = A;
                    acc_d   = '0;
                    cnt_d   = '0;
                    low_d   = op[1] ? mag_a : mag_b;
                    opb_d   = op[1] ? mag_b : mag_a;
                    state_d = StRun;
                end else begin
                    if (mthi) hi_d = A;
                    if (mtlo) lo_d = A;
                end
            end
            StRun: begin
                if (flush) begin
                    state_d = StIdle;
                end else begin
                    if (op_q[1]) begin
                        // Restoring step: the 33-bit compare keeps the shifted-out MSB
                        if (div_shift >= {1'b0, opb_q}) begin
                            acc_d = div_shift[XLEN-1:0] - opb_q;
                            low_d = {low_q[XLEN-2:0], 1'b1};
                        end else begin
                            acc_d = div_shift[XLEN-1:0];
                            low_d = {low_q[XLEN-2:0], 1'b0};
                        end
                    end else begin
                        acc_d = mul_sum[XLEN:1];
                        low_d = {mul_sum[0], low_q[XLEN-1:1]};
                    end
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CntW'(ITER - 1)) state_d = StFin;
                end
            end
            StFin: begin
                state_d = StIdle;
                if (!flush) begin
                    done_d = 1'b1;
                    if (!op_q[1]) begin
                        hi_d = prod_fix[2*XLEN-1:XLEN];
                        lo_d = prod_fix[XLEN-1:0];
                    end else if (bz_q) begin
                        hi_d = a_raw_q;
                        lo_d = {XLEN{1'b1}};
                    end else begin
                        hi_d = rem_fix;
                        lo_d = quot_fix;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            op_q    <= '0;
            sa_q    <= 1'b0;
            sb_q    <= 1'b0;
            bz_q    <= 1'b0;
            a_raw_q <= '0;
            acc_q   <= '0;
            low_q   <= '0;
            opb_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            bz_q    <= bz_d;
            a_raw_q <= a_raw_d;
            acc_q   <= acc_d;
            low_q   <= low_d;
            opb_q   <= opb_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign hi   = hi_q;
    assign lo   = lo_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: doc/muldiv_seq.md
Name: muldiv_seq

Overview:
- Iterative multiply/divide sequencer for the pipeline execute stage. Owns the architectural HI/LO registers.
- Services MULT/MULTU/DIV/DIVU that the single-cycle ALU cannot do, using one shared 32-step shift/add-subtract datapath.
- Exposes a busy handshake so the hazard unit stalls any MFHI/MFLO or new mul/div issue until the result is written.

Parameters:
- XLEN, 32, operand and HI/LO width.
- ITER, 32, iterations per operation; must equal XLEN.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset; synchronous, active-high.
- start  in  1  issue request; sampled only when busy=0.
- op  in  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- A  in  XLEN  multiplicand or dividend (rs).
- B  in  XLEN  multiplier or divisor (rt).
- flush  in  1  cancel the in-flight operation (branch/exception squash).
- mthi  in  1  write A into HI; honoured only when idle.
- mtlo  in  1  write A into LO; honoured only when idle.
- hi  out  XLEN  HI register.
- lo  out  XLEN  LO register.
- busy  out  1  operation in flight.
- done  out  1  one-cycle pulse: HI/LO updated by a completed operation.

Behaviour:
- States:
  - IDLE -> RUN on start.
  - RUN -> RUN while the iteration counter is below ITER-1.
  - RUN -> FIN after the ITER-th step.
  - FIN -> IDLE.
- Reset (rst=1 at an edge): state=IDLE, hi=0, lo=0, busy=0, done=0, counter=0, internal regs=0. Applies from any state; an in-flight operation is discarded.
- busy=1 exactly in RUN and FIN. busy is a registered output.
- Latency:
  - start sampled at edge E0.
  - busy=1 from E0 through E0+33.
  - hi/lo written at edge E0+33.
  - done=1 for the single cycle after E0+33, then 0.
  - Latency is fixed at 33 edges for every op and operand, including divide-by-zero.
- Issue (E0):
  - Latch op.
  - Signed ops latch |A| and |B| plus sign bits sA, sB; unsigned ops latch A and B unchanged.
  - Counter=0.
- MULT/MULTU (RUN): shift-add over the 64-bit product register, one multiplier bit per cycle, LSB first.
- DIV/DIVU (RUN): restoring division, one quotient bit per cycle, MSB first. Uses a 33-bit partial remainder to avoid overflow on unsigned compare.
- FIN, sign fixup:
  - Signed multiply: negate the 64-bit product if sA^sB.
  - Signed divide: negate the quotient if sA^sB; negate the remainder if sA.
  - Then hi = product[63:32], lo = product[31:0] for multiply; hi = remainder, lo = quotient for divide.
- Divide by zero (B=0, signed or unsigned): lo=32'hFFFFFFFF, hi=A (original, unsigned view); no sign fixup; full latency still applies.
- Signed overflow DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0. This falls out naturally from the magnitude algorithm.
- Priority when IDLE, same cycle:
  - start wins over mthi/mtlo; the writes are dropped.
  - mthi and mtlo together with no start: both written with A.
- start, mthi or mtlo while busy: ignored. No queueing and no corruption of the in-flight operation; the hazard unit guarantees a stall.
- flush:
  - In RUN or FIN: next state IDLE, hi/lo unchanged, no done pulse.
  - In IDLE: flush has priority over start, so a same-cycle start is not accepted.
  - rst has priority over flush.
- Outputs hi/lo change only on reset, mthi/mtlo, or a FIN edge.

Test Plan:
- MULTU A=0xFFFFFFFF, B=0xFFFFFFFF -> done one cycle after the 33rd edge; hi=0xFFFFFFFE, lo=0x00000001; busy high for exactly 33 cycles.
- MULT A=-3 (0xFFFFFFFD), B=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB. Back-to-back: start asserted in the done cycle -> accepted, busy reasserts the next cycle.
- DIV A=-7, B=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU A=0xFFFFFFF9, B=2 -> lo=0x7FFFFFFC, hi=1.
- DIVU A=100, B=0 -> lo=0xFFFFFFFF, hi=100, same 33-edge latency. DIV A=0x80000000, B=0xFFFFFFFF -> lo=0x80000000, hi=0.
- mthi A=0x12345678 while idle -> hi=0x12345678. Then start MULT 2*3 and pulse mtlo at cycle 5 -> mtlo ignored; final hi=0, lo=6.
- After mthi/mtlo set hi=0xAAAA0000 and lo=0x0000BBBB, start DIV 10/3, flush at cycle 10 -> busy drops next cycle, no done, hi/lo unchanged. Repeat with rst at cycle 20 -> hi=lo=0, busy=0, done=0.
